repetition_expander: RTL and testbench



---
 rtl/repetition_expander_pkg.sv | 22 ++
 rtl/repetition_expander_decode.sv | 41 ++++
 rtl/repetition_expander.sv | 175 +++++++++++++++++
 tb/tb_repetition_expander.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/repetition_expander_pkg.sv
// rtl/repetition_expander_pkg.sv - shared state enum, default parameters and rep-info indexing
package repetition_expander_pkg;

    localparam int DEF_DATA_WIDTH             = 8;
    localparam int DEF_GROUP_SIZE             = 4;
    localparam int DEF_LOG_MAX_ITERS          = 16;
    localparam int DEF_LOG_MAX_READS_PER_ITER = 16;
    localparam int DEF_IN_WIDTH               = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_VAL,
        ST_OUT
    } state_e;

    // Bit position saying "element k repeats element l"; also used by repetition_detector.
    function automatic int rep_idx(input int k, input int l, input int group_size);
        return k * group_size + l;
    endfunction

endpackage

// File: rtl/repetition_expander_decode.sv
// rtl/repetition_expander_decode.sv - rep info to unique count, unique-slot rank and source index
module rep_info_decode
    import repetition_expander_pkg::*;
#(
    parameter int GROUP_SIZE    = DEF_GROUP_SIZE,
    parameter int REP_INFO_BITS = GROUP_SIZE * GROUP_SIZE,
    parameter int CW            = $clog2(GROUP_SIZE + 1),
    parameter int IW            = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1
) (
    input  logic [REP_INFO_BITS-1:0]     rep_info,
    output logic [CW-1:0]                num_unique,
    output logic [GROUP_SIZE-1:0]        is_unique,
    output logic [GROUP_SIZE-1:0][IW-1:0] rank,
    output logic [GROUP_SIZE-1:0][IW-1:0] src
);

    always_comb begin
        logic [CW-1:0] n;
        n          = '0;
        is_unique  = '0;
        rank       = '0;
        src        = '0;
        for (int k = 0; k < GROUP_SIZE; k++) begin
            is_unique[k] = 1'b1;
            src[k]       = IW'(k);
            // Walk downwards so the lowest set l wins; l >= k never counts.
            for (int l = GROUP_SIZE - 1; l >= 0; l--) begin
                if (l < k && rep_info[rep_idx(k, l, GROUP_SIZE)]) begin
                    is_unique[k] = 1'b0;
                    src[k]       = IW'(l);
                end
            end
            rank[k] = n[IW-1:0];
            if (is_unique[k]) begin
                n = n + CW'(1);
            end
        end
        num_unique = n;
    end

endmodule

// File: rtl/repetition_expander.sv
// rtl/repetition_expander.sv - rebuilds groups from a header beat plus one beat per unique element
module repetition_expander
    import repetition_expander_pkg::*;
#(
    parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
    parameter int GROUP_SIZE             = DEF_GROUP_SIZE,
    parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
    parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER,
    parameter int REP_INFO_BITS          = GROUP_SIZE * GROUP_SIZE,
    parameter int IN_WIDTH               = DEF_IN_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [IN_WIDTH-1:0]               data_in,
    input  logic                             valid_in,
    output logic                             avail_out,
    output logic [GROUP_SIZE*DATA_WIDTH-1:0]  data_out,
    output logic                             valid_out,
    input  logic                             avail_in,
    output logic                             done
);

    localparam int CW = $clog2(GROUP_SIZE + 1);
    localparam int IW = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
    localparam int LR = LOG_MAX_READS_PER_ITER;
    localparam logic [LOG_MAX_ITERS-1:0] ITER_ONE   = 1;
    localparam logic [LR:0]              GROUP_STEP = (LR + 1)'(GROUP_SIZE);

    state_e                          state_q, state_d;
    logic [REP_INFO_BITS-1:0]        rep_q, rep_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]           vals_q [GROUP_SIZE];
    logic [DATA_WIDTH-1:0]           vals_d [GROUP_SIZE];
    logic [DATA_WIDTH-1:0]           vals_nx [GROUP_SIZE];
    logic [GROUP_SIZE*DATA_WIDTH-1:0] dout_q, dout_d, resolved;
    logic [LR-1:0]                   reads_q, reads_d, nr_q, nr_d;
    logic [LOG_MAX_ITERS-1:0]        iters_q, iters_d, ni_q, ni_d;
    logic                            done_q, done_d;

    logic [CW-1:0]                   num_unique;
    logic [GROUP_SIZE-1:0]           is_unique;
    logic [GROUP_SIZE-1:0][IW-1:0]   rank, src;
    logic                            take, group_wrap, last_group;
    logic [LR:0]                     reads_plus;

    rep_info_decode #(
        .GROUP_SIZE    (GROUP_SIZE),
        .REP_INFO_BITS (REP_INFO_BITS),
        .CW            (CW),
        .IW            (IW)
    ) u_decode (
        .rep_info   (rep_q),
        .num_unique (num_unique),
        .is_unique  (is_unique),
        .rank       (rank),
        .src        (src)
    );

    assign avail_out  = (state_q == ST_HDR) || (state_q == ST_VAL);
    assign valid_out  = (state_q == ST_OUT);
    assign data_out   = dout_q;
    assign done       = done_q;
    assign take       = valid_in && avail_out;
    assign reads_plus = {1'b0, reads_q} + GROUP_STEP;
    assign group_wrap = reads_plus >= {1'b0, nr_q};
    assign last_group = group_wrap && (iters_q == ni_q - ITER_ONE);

    // Resolve elements in ascending k so a repeat always reads an already-resolved source.
    always_comb begin
        logic [DATA_WIDTH-1:0] res [GROUP_SIZE];
        vals_nx = vals_q;
        if (state_q == ST_VAL && valid_in) begin
            vals_nx[cnt_q[IW-1:0]] = data_in[DATA_WIDTH-1:0];
        end
        res      = '{default: '0};
        resolved = '0;
        for (int k = 0; k < GROUP_SIZE; k++) begin
            if (is_unique[k]) begin
                res[k] = vals_nx[rank[k]];
            end else begin
                res[k] = res[src[k]];
            end
            resolved[k*DATA_WIDTH +: DATA_WIDTH] = res[k];
        end
    end

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        cnt_d   = cnt_q;
        vals_d  = vals_q;
        dout_d  = dout_q;
        reads_d = reads_q;
        iters_d = iters_q;
        ni_d    = ni_q;
        nr_d    = nr_q;
        done_d  = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (take) begin
                    rep_d   = data_in[REP_INFO_BITS-1:0];
                    cnt_d   = '0;
                    state_d = ST_VAL;
                end
            end
            ST_VAL: begin
                if (take) begin
                    vals_d = vals_nx;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == num_unique - CW'(1)) begin
                        dout_d  = resolved;
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (avail_in) begin
                    if (group_wrap) begin
                        reads_d = '0;
                        iters_d = iters_q + ITER_ONE;
                    end else begin
                        reads_d = reads_plus[LR-1:0];
                    end
                    if (last_group) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
            end
            default: ;
        endcase
        // A new configuration abandons whatever group was in flight.
        if (configure) begin
            state_d = (num_iters != '0 && num_reads_per_iter != '0) ? ST_HDR : ST_IDLE;
            cnt_d   = '0;
            reads_d = '0;
            iters_d = '0;
            ni_d    = num_iters;
            nr_d    = num_reads_per_iter;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rep_q   <= '0;
            cnt_q   <= '0;
            vals_q  <= '{default: '0};
            dout_q  <= '0;
            reads_q <= '0;
            iters_q <= '0;
            ni_q    <= '0;
            nr_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            vals_q  <= vals_d;
            dout_q  <= dout_d;
            reads_q <= reads_d;
            iters_q <= iters_d;
            ni_q    <= ni_d;
            nr_q    <= nr_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_repetition_expander.sv
// tb/tb_repetition_expander.sv - directed and randomized bench with a rule-level group model
module tb_repetition_expander;

    logic        clk = 1'b0;
    logic        rst;
    logic        configure;
    logic [15:0] num_iters;
    logic [15:0] num_reads_per_iter;
    logic [15:0] data_in;
    logic        valid_in;
    logic        avail_out;
    logic [31:0] data_out;
    logic        valid_out;
    logic        avail_in;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    repetition_expander dut (
        .clk                (clk),
        .rst                (rst),
        .configure          (configure),
        .num_iters          (num_iters),
        .num_reads_per_iter (num_reads_per_iter),
        .data_in            (data_in),
        .valid_in           (valid_in),
        .avail_out          (avail_out),
        .data_out           (data_out),
        .valid_out          (valid_out),
        .avail_in           (avail_in),
        .done               (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Number of elements with no earlier element marked as their original.
    function automatic int model_u(input logic [15:0] h);
        int u = 0;
        for (int k = 0; k < 4; k++) begin
            bit rep = 0;
            for (int l = 0; l < k; l++) if (h[k*4+l]) rep = 1;
            if (!rep) u++;
        end
        return u;
    endfunction

    function automatic logic [31:0] model_out(input logic [15:0] h, input logic [31:0] vals);
        logic [7:0] q[$];
        logic [7:0] e[4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) q.push_back(vals[i*8 +: 8]);
        for (int k = 0; k < 4; k++) begin
            int orig = -1;
            for (int l = 0; l < k; l++) if (h[k*4+l] && orig < 0) orig = l;
            e[k] = (orig < 0) ? q.pop_front() : e[orig];
        end
        r = {e[3], e[2], e[1], e[0]};
        return r;
    endfunction

    task automatic do_config(input logic [15:0] ni, input logic [15:0] nr);
        configure = 1'b1; num_iters = ni; num_reads_per_iter = nr;
        @(negedge clk);
        configure = 1'b0;
    endtask

    task automatic put(input logic [15:0] d, input string tag);
        int t = 0;
        data_in = d; valid_in = 1'b1;
        while (!avail_out && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_accept"}, avail_out, 1);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic run_group(input logic [15:0] hdr, input logic [31:0] vals, input bit last,
                             input int stall, input string tag);
        int          u;
        logic [31:0] exp;
        logic [15:0] junk;
        u   = model_u(hdr);
        exp = model_out(hdr, vals);
        put(hdr, {tag, "_hdr"});
        for (int i = 0; i < u; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            check({tag, "_no_early_valid"}, valid_out, 0);
            junk = 16'($urandom);
            put({junk[15:8], vals[i*8 +: 8]}, {tag, "_val"});
        end
        check({tag, "_valid_out"}, valid_out, 1);
        check({tag, "_avail_out_in_out"}, avail_out, 0);
        check({tag, "_data_out"}, data_out, exp);
        for (int s = 0; s < stall; s++) begin
            valid_in = 1'b1; data_in = 16'($urandom);
            @(negedge clk);
            check({tag, "_stall_valid"}, valid_out, 1);
            check({tag, "_stall_avail"}, avail_out, 0);
            check({tag, "_stall_data"}, data_out, exp);
        end
        valid_in = 1'b0;
        avail_in = 1'b1;
        @(negedge clk);
        avail_in = 1'b0;
        check({tag, "_done"}, done, last);
        check({tag, "_valid_after"}, valid_out, 0);
        check({tag, "_avail_after"}, avail_out, !last);
        if (last) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_idle"}, avail_out, 0);
        end
    endtask

    initial begin
        logic [15:0] h;
        logic [31:0] v;
        rst = 1'b0; configure = 1'b0; num_iters = '0; num_reads_per_iter = '0;
        data_in = '0; valid_in = 1'b0; avail_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid_out", valid_out, 0);
        check("rst_avail_out", avail_out, 0);
        check("rst_done", done, 0);
        check("rst_data_out", data_out, 0);
        rst = 1'b1;
        @(negedge clk);

        do_config(16'd0, 16'd4);
        @(negedge clk);
        check("zero_iters_idle", avail_out, 0);
        do_config(16'd1, 16'd0);
        @(negedge clk);
        check("zero_reads_idle", avail_out, 0);

        do_config(16'd1, 16'd4);
        run_group(16'h0000, 32'h03020100, 1, 0, "all_unique");
        do_config(16'd1, 16'd4);
        run_group(16'h0010, 32'h00030200, 1, 0, "one_repeat");
        do_config(16'd1, 16'd4);
        run_group(16'h1110, 32'h0000005A, 1, 0, "broadcast");
        do_config(16'd1, 16'd4);
        run_group(16'h8888, 32'h44332211, 1, 0, "ignored_bits");
        do_config(16'd1, 16'd4);
        run_group(16'h0000, 32'hDDCCBBAA, 1, 5, "stall");

        do_config(16'd2, 16'd6);
        for (int g = 0; g < 4; g++) begin
            h = 16'($urandom);
            v = $urandom;
            run_group(h, v, g == 3, 0, "round_up");
        end

        do_config(16'd1, 16'd4);
        put(16'h0000, "abort_hdr");
        put(16'h0077, "abort_val");
        do_config(16'd1, 16'd4);
        run_group(16'h0100, 32'h00C0B0A0, 1, 0, "after_abort");

        do_config(16'd1, 16'd4);
        put(16'h0000, "rst_mid_hdr");
        put(16'h0011, "rst_mid_val");
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", valid_out, 0);
        check("async_rst_avail", avail_out, 0);
        check("async_rst_done", done, 0);
        check("async_rst_data", data_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_config(16'd1, 16'd4);
        run_group(16'h2010, 32'h00009988, 1, 0, "after_rst");

        do_config(16'd3, 16'd16);
        for (int g = 0; g < 12; g++) begin
            h = 16'($urandom);
            v = $urandom;
            run_group(h, v, g == 11, $urandom_range(0, 2), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
